// File: rtl/i2c_pkg.sv
// Shared constants and bus-state type for the I2C input conditioning path.
// Defaults assume a 100 MHz system clock.
package i2c_pkg;

    localparam int I2C_FILT_CYCLES_DEF    = 5;
    localparam int I2C_TIMEOUT_CYCLES_DEF = 2_500_000;
    localparam int I2C_FILT_W             = 8;
    localparam int I2C_TO_W               = 22;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } i2c_bus_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Single-line 2-FF synchroniser followed by a spike filter.
// A level must be seen for FILT_CYCLES consecutive samples before it propagates.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILT_CYCLES = I2C_FILT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic chg_o
);

    localparam logic [I2C_FILT_W-1:0] LP_LAST = I2C_FILT_W'(FILT_CYCLES - 1);

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_f;
    logic                  r_chg;
    logic [I2C_FILT_W-1:0] r_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_f   <= 1'b1;
            r_chg <= 1'b0;
            r_c   <= '0;
        end else begin
            r_s1  <= line_i;
            r_s2  <= r_s1;
            r_chg <= 1'b0;
            if (r_s2 != r_f) begin
                // This mismatch is the FILT_CYCLES-th in a row: accept it.
                if (r_c == LP_LAST) begin
                    r_f   <= r_s2;
                    r_chg <= 1'b1;
                    r_c   <= '0;
                end else begin
                    r_c <= r_c + 1'b1;
                end
            end else begin
                r_c <= '0;
            end
        end
    end

    assign level_o = r_f;
    assign chg_o   = r_chg;

endmodule

// File: rtl/i2c_bus_filter.sv
// Filtered SCL/SDA levels, edge and START/STOP strobes, and bus-busy tracking.
// Define I2C_TIMEOUT_EN to enable the SCL-low timeout that releases a stuck bus.
module i2c_bus_filter
    import i2c_pkg::*;
#(
    parameter int FILT_CYCLES    = I2C_FILT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout
);

    logic           w_scl_chg;
    logic           w_sda_chg;
    logic           w_timeout;
    i2c_bus_state_t r_state;

    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_i),
        .level_o (scl_o),
        .chg_o   (w_scl_chg)
    );

    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_i),
        .level_o (sda_o),
        .chg_o   (w_sda_chg)
    );

    assign scl_rise  = w_scl_chg & scl_o;
    assign scl_fall  = w_scl_chg & ~scl_o;
    // SDA moving in the same cycle as SCL is ambiguous, so it is not a condition.
    assign start_det = w_sda_chg & ~sda_o & scl_o & ~w_scl_chg;
    assign stop_det  = w_sda_chg & sda_o & scl_o & ~w_scl_chg;

`ifdef I2C_TIMEOUT_EN
    localparam logic [I2C_TO_W-1:0] LP_TO_LAST = I2C_TO_W'(TIMEOUT_CYCLES - 1);

    logic [I2C_TO_W-1:0] r_to_cnt;
    logic                w_scl_held;

    assign w_scl_held = (r_state == BUS_BUSY) & ~scl_o;
    assign w_timeout  = w_scl_held & (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_scl_held && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_to;

    assign w_unused_to = ^TIMEOUT_CYCLES;
    assign w_timeout   = 1'b0;
`endif

    assign timeout = w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUS_IDLE;
        end else begin
            unique case (r_state)
                BUS_IDLE: if (start_det) r_state <= BUS_BUSY;
                BUS_BUSY: if (stop_det || w_timeout) r_state <= BUS_IDLE;
                default:  r_state <= BUS_IDLE;
            endcase
        end
    end

    assign bus_busy = (r_state == BUS_BUSY);

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Directed bench for i2c_bus_filter with a per-cycle behavioural model.
// Timeout expectations follow I2C_TIMEOUT_EN.
module tb_i2c_bus_filter;

    localparam int FILT = 5;
    localparam int TO   = 100;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic scl_i = 1'b1;
    logic sda_i = 1'b1;
    logic scl_o, sda_o, scl_rise, scl_fall;
    logic start_det, stop_det, bus_busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise, n_fall, n_start, n_stop, n_to, n_sdalow;

    i2c_bus_filter #(.FILT_CYCLES(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_o     (scl_o),
        .sda_o     (sda_o),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .bus_busy  (bus_busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Model: a filtered line flips once the FILT most recent synchronised
    // samples (pad value two clocks ago and older) all disagree with it, and
    // at least FILT clocks have elapsed since its previous flip or reset.
    bit m_scl = 1, m_sda = 1, m_scl_chg = 0, m_sda_chg = 0;
    bit m_rise = 0, m_fall = 0, m_start = 0, m_stop = 0;
    bit m_busy = 0, m_to = 0;
    int ed = 0, scl_last = 0, sda_last = 0, lowrun = 0;
    bit qs[$];
    bit qd[$];

    function automatic bit flip_due(input bit h[$], input bit f, input int since);
        if (since < FILT) return 1'b0;
        for (int k = 2; k <= FILT + 1; k++) begin
            bit s;
            s = (k < h.size()) ? h[k] : 1'b1;
            if (s == f) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_scl = 1; m_sda = 1; m_scl_chg = 0; m_sda_chg = 0;
            m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
            m_busy = 0; m_to = 0;
            ed = 0; scl_last = 0; sda_last = 0; lowrun = 0;
            qs.delete();
            qd.delete();
        end else begin
            ed++;
            if (m_start) m_busy = 1;
            else if (m_stop || m_to) m_busy = 0;
            qs.push_front(scl_i);
            qd.push_front(sda_i);
            if (qs.size() > FILT + 2) void'(qs.pop_back());
            if (qd.size() > FILT + 2) void'(qd.pop_back());
            m_scl_chg = flip_due(qs, m_scl, ed - scl_last);
            m_sda_chg = flip_due(qd, m_sda, ed - sda_last);
            if (m_scl_chg) begin m_scl = ~m_scl; scl_last = ed; end
            if (m_sda_chg) begin m_sda = ~m_sda; sda_last = ed; end
            m_rise  = m_scl_chg && m_scl;
            m_fall  = m_scl_chg && !m_scl;
            m_start = m_sda_chg && !m_scl_chg && m_scl && !m_sda;
            m_stop  = m_sda_chg && !m_scl_chg && m_scl && m_sda;
`ifdef I2C_TIMEOUT_EN
            lowrun = (m_busy && !m_scl) ? lowrun + 1 : 0;
            m_to   = (lowrun == TO);
`else
            m_to   = 0;
`endif
        end
    end

    always @(negedge clk) begin
        logic [7:0] act, exp;
        act = {scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout};
        exp = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_to};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t act=%b exp=%b", $time, act, exp);
        end
        if (!rst) begin
            n_rise   += int'(scl_rise);
            n_fall   += int'(scl_fall);
            n_start  += int'(start_det);
            n_stop   += int'(stop_det);
            n_to     += int'(timeout);
            n_sdalow += int'(!sda_o);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clr();
        n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_to = 0; n_sdalow = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sbit(input bit d);
        scl_i = 1'b0;
        cyc(30);
        sda_i = d;
        cyc(32);
        scl_i = 1'b1;
        cyc(63);
    endtask

    // Clocks from a pad step (applied just before) until scl_o or sda_o is low.
    task automatic wait_low(input bit use_scl, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((use_scl ? scl_o : sda_o) == 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int lowcnt;
        int to_at;
        #1 rst = 1'b1;
        cyc(3);
        check("rst_scl_o", int'(scl_o), 1);
        check("rst_sda_o", int'(sda_o), 1);
        check("rst_busy", int'(bus_busy), 0);
        check("rst_strobes", int'({scl_rise, scl_fall, start_det, stop_det, timeout}), 0);
        rst = 1'b0;
        cyc(5);

        clr();
        sda_i = 1'b0;
        cyc(3);
        sda_i = 1'b1;
        cyc(15);
        check("glitch_sda_low", n_sdalow, 0);
        check("glitch_start", n_start, 0);
        check("glitch_busy", int'(bus_busy), 0);

        clr();
        sda_i = 1'b0;
        wait_low(1'b0, lat);
        check("start_latency", lat, 7);
        check("start_same_cycle", int'(start_det), 1);
        @(posedge clk);
        #1;
        check("start_busy", int'(bus_busy), 1);
        #1;
        cyc(12);
        check("start_count", n_start, 1);

        clr();
        sbit(1); sbit(0); sbit(1); sbit(1);
        sbit(0); sbit(0); sbit(1); sbit(1);
        check("byte_rises", n_rise, 8);
        check("byte_falls", n_fall, 8);
        check("byte_start", n_start, 0);
        check("byte_stop", n_stop, 0);
        check("byte_busy", int'(bus_busy), 1);

        clr();
        sda_i = 1'b0;
        cyc(20);
        check("rstart_count", n_start, 1);
        check("rstart_busy", int'(bus_busy), 1);
        scl_i = 1'b0;
        cyc(20);
        scl_i = 1'b1;
        cyc(20);
        sda_i = 1'b1;
        cyc(20);
        check("stop_count", n_stop, 1);
        check("stop_busy", int'(bus_busy), 0);

        clr();
        scl_i = 1'b0;
        sda_i = 1'b0;
        wait_low(1'b1, lat);
        check("simul_latency", lat, 7);
        check("simul_sda_o", int'(sda_o), 0);
        check("simul_scl_fall", int'(scl_fall), 1);
        check("simul_start", int'(start_det), 0);
        #1;
        cyc(10);
        scl_i = 1'b1;
        sda_i = 1'b1;
        cyc(15);
        check("simul_no_start", n_start, 0);
        check("simul_no_stop", n_stop, 0);
        check("simul_busy", int'(bus_busy), 0);

        clr();
        sda_i = 1'b0;
        cyc(15);
        scl_i = 1'b0;
`ifdef I2C_TIMEOUT_EN
        lowcnt = 0;
        to_at  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!scl_o) lowcnt++;
            if (timeout) begin
                to_at = lowcnt;
                break;
            end
        end
        check("timeout_at", to_at, TO);
        @(negedge clk);
        check("timeout_busy", int'(bus_busy), 0);
        @(posedge clk);
        #2;
        cyc(20);
        check("timeout_count", n_to, 1);
`else
        lowcnt = 0;
        to_at  = 0;
        cyc(150);
        check("no_timeout_count", n_to, 0);
        check("no_timeout_busy", int'(bus_busy), 1);
`endif
        scl_i = 1'b1;
        cyc(15);
        sda_i = 1'b1;
        cyc(15);
        check("to_end_busy", int'(bus_busy), 0);

        clr();
        sda_i = 1'b0;
        cyc(15);
        sbit(1);
        sbit(0);
        scl_i = 1'b0;
        cyc(30);
        check("mid_busy", int'(bus_busy), 1);
        #1 rst = 1'b1;
        #1;
        check("async_scl_o", int'(scl_o), 1);
        check("async_sda_o", int'(sda_o), 1);
        check("async_busy", int'(bus_busy), 0);
        check("async_strobes", int'({scl_rise, scl_fall, start_det, stop_det, timeout}), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        clr();
        wait_low(1'b1, lat);
        check("post_rst_latency", lat, 7);
        check("post_rst_sda_o", int'(sda_o), 0);
        check("post_rst_start", int'(start_det), 0);
        #1;
        cyc(5);
        scl_i = 1'b1;
        cyc(15);
        sda_i = 1'b1;
        cyc(15);
        check("post_rst_no_start", n_start, 0);
        check("post_rst_busy", int'(bus_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
